// File: rtl/hdmi_pattern_check.sv
// HDMI TX test-pattern checker: captures each frame's flat colour, tracks
// the generator's red sequence, and reports lock/frame/error status.
//
// Ports:
//   HDMI_TX_CLK  pixel clock; VS/DE/D are synchronous to it
//   reset_n      asynchronous active-low reset
//   HDMI_TX_VS   vertical sync; a falling edge closes a frame
//   HDMI_TX_DE   data enable for active pixels
//   HDMI_TX_D    pixel {R,G,B}
//   locked       sequence tracked
//   frame_done   1-cycle pulse after each evaluated frame
//   frame_ok     result of the last evaluated frame
//   pix_err      1-cycle pulse when a DE pixel differs from the frame's first
//   cur_red      red value of the last evaluated frame
//   frame_count  evaluated frames, saturating
//   err_count    bad frames while locked, saturating
module hdmi_pattern_check #(
    parameter int LOCK_FRAMES = 4,
    parameter int LOSS_FRAMES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             HDMI_TX_CLK,
    input  logic             reset_n,
    input  logic             HDMI_TX_VS,
    input  logic             HDMI_TX_DE,
    input  logic [23:0]      HDMI_TX_D,
    output logic             locked,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             pix_err,
    output logic [7:0]       cur_red,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int GW = $clog2(LOCK_FRAMES + 1);
    localparam int BW = $clog2(LOSS_FRAMES + 1);

    localparam logic [GW-1:0]    G_ONE   = GW'(1);
    localparam logic [GW-1:0]    G_LOCK  = GW'(LOCK_FRAMES);
    localparam logic [BW-1:0]    B_ONE   = BW'(1);
    localparam logic [BW-1:0]    B_LOSS  = BW'(LOSS_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Red sequence step; 254 is shown twice, tracked by the rep flag.
    // Result is {rep_next, red_next}.
    function automatic logic [8:0] nxt(input logic [7:0] r,
                                       input logic       rp);
        logic [8:0] res;
        if (r == 8'd254)
            res = rp ? {1'b0, 8'd0} : {1'b1, 8'd254};
        else
            res = {1'b0, r + 8'd1};
        return res;
    endfunction

    // Per-frame capture state
    logic        vs_d;
    logic        fall;
    logic        seen_de;
    logic        mismatch;
    logic [23:0] cap_rgb;

    // Sequence tracking state
    state_t         state, state_n;
    logic [7:0]     exp_red, exp_n;
    logic           rep, rep_n;
    logic [GW-1:0]  good_cnt, good_n;
    logic [BW-1:0]  bad_cnt, bad_n;
    logic           locked_n;
    logic           done_n;
    logic           ok_n;
    logic [7:0]     red_n;
    logic [CNT_W-1:0] fcnt_n;
    logic [CNT_W-1:0] ecnt_n;

    logic [7:0] cap_r, cap_g, cap_b, r_m1;
    logic       uniform, consist, seq_ok, good;

    assign fall = vs_d & ~HDMI_TX_VS;

    // A DE pixel on the fall cycle opens the new frame; the closing
    // frame is evaluated from the flags as they stood before this edge.
    always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            vs_d     <= 1'b0;
            seen_de  <= 1'b0;
            mismatch <= 1'b0;
            cap_rgb  <= '0;
            pix_err  <= 1'b0;
        end else begin
            vs_d    <= HDMI_TX_VS;
            pix_err <= 1'b0;
            if (fall) begin
                seen_de  <= HDMI_TX_DE;
                mismatch <= 1'b0;
                cap_rgb  <= HDMI_TX_DE ? HDMI_TX_D : 24'd0;
            end else if (HDMI_TX_DE) begin
                if (!seen_de) begin
                    seen_de <= 1'b1;
                    cap_rgb <= HDMI_TX_D;
                end else if (HDMI_TX_D != cap_rgb) begin
                    mismatch <= 1'b1;
                    pix_err  <= 1'b1;
                end
            end
        end
    end

    assign cap_r   = cap_rgb[23:16];
    assign cap_g   = cap_rgb[15:8];
    assign cap_b   = cap_rgb[7:0];
    assign r_m1    = cap_r - 8'd1;
    assign uniform = seen_de & ~mismatch;
    assign consist = (cap_g == r_m1) & (cap_b == r_m1);
    assign seq_ok  = (cap_r == exp_red);
    assign good    = uniform & consist & seq_ok;

    always_ff @(posedge HDMI_TX_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SEEK;
            exp_red     <= 8'd0;
            rep         <= 1'b0;
            good_cnt    <= '0;
            bad_cnt     <= '0;
            locked      <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            cur_red     <= 8'd0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            exp_red     <= exp_n;
            rep         <= rep_n;
            good_cnt    <= good_n;
            bad_cnt     <= bad_n;
            locked      <= locked_n;
            frame_done  <= done_n;
            frame_ok    <= ok_n;
            cur_red     <= red_n;
            frame_count <= fcnt_n;
            err_count   <= ecnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        exp_n    = exp_red;
        rep_n    = rep;
        good_n   = good_cnt;
        bad_n    = bad_cnt;
        locked_n = locked;
        done_n   = 1'b0;
        ok_n     = frame_ok;
        red_n    = cur_red;
        fcnt_n   = frame_count;
        ecnt_n   = err_count;

        if (fall) begin
            unique case (state)
                SEEK: begin
                    // Partial frame since reset: just sync up.
                    state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    done_n = 1'b1;
                    red_n  = cap_r;
                    fcnt_n = (&frame_count) ? frame_count
                                            : frame_count + CNT_ONE;
                    // 254 is ambiguous (first or repeat), so never seed on it.
                    if (uniform && consist && cap_r != 8'd254) begin
                        ok_n = (good_cnt == '0) || seq_ok;
                        if (good_cnt != '0 && seq_ok)
                            good_n = good_cnt + G_ONE;
                        else
                            good_n = G_ONE;
                        {rep_n, exp_n} = nxt(cap_r, 1'b0);
                        if (good_n == G_LOCK) begin
                            state_n  = LOCKED;
                            locked_n = 1'b1;
                            bad_n    = '0;
                        end
                    end else begin
                        ok_n   = 1'b0;
                        good_n = '0;
                    end
                end
                LOCKED: begin
                    done_n = 1'b1;
                    red_n  = cap_r;
                    fcnt_n = (&frame_count) ? frame_count
                                            : frame_count + CNT_ONE;
                    // Expected red advances regardless so one bad frame
                    // does not desynchronise the tracker.
                    {rep_n, exp_n} = nxt(exp_red, rep);
                    if (good) begin
                        ok_n  = 1'b1;
                        bad_n = '0;
                    end else begin
                        ok_n   = 1'b0;
                        ecnt_n = (&err_count) ? err_count
                                              : err_count + CNT_ONE;
                        bad_n  = bad_cnt + B_ONE;
                        if (bad_n == B_LOSS) begin
                            state_n  = ACQUIRE;
                            locked_n = 1'b0;
                            good_n   = '0;
                            bad_n    = '0;
                        end
                    end
                end
                default: begin
                    state_n = SEEK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdmi_pattern_check.sv
// Directed bench for hdmi_pattern_check: reset, acquisition, lock through
// the 254 repeat, pixel errors, empty frames, DE on fall, counter saturation.
module tb_hdmi_pattern_check;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vs = 1'b0;
    logic          de = 1'b0;
    logic [23:0]   d = '0;
    logic          locked, frame_done, frame_ok, pix_err;
    logic [7:0]    cur_red;
    logic [CW-1:0] frame_count, err_count;

    int n_chk  = 0;
    int n_fail = 0;

    int         ndone = 0;
    int         npix  = 0;
    logic       last_ok;
    logic [7:0] last_red;

    always #5 clk = ~clk;

    hdmi_pattern_check #(
        .LOCK_FRAMES(4),
        .LOSS_FRAMES(2),
        .CNT_W(CW)
    ) dut (
        .HDMI_TX_CLK(clk),
        .reset_n(reset_n),
        .HDMI_TX_VS(vs),
        .HDMI_TX_DE(de),
        .HDMI_TX_D(d),
        .locked(locked),
        .frame_done(frame_done),
        .frame_ok(frame_ok),
        .pix_err(pix_err),
        .cur_red(cur_red),
        .frame_count(frame_count),
        .err_count(err_count)
    );

    always @(negedge clk) begin
        if (frame_done) begin
            ndone    <= ndone + 1;
            last_ok  <= frame_ok;
            last_red <= cur_red;
        end
        if (pix_err)
            npix <= npix + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic e,
                         input logic [23:0] px);
        @(negedge clk);
        vs = v;
        de = e;
        d  = px;
    endtask

    // Frame body, then a VS pulse whose falling edge closes it.
    task automatic send_frame(input logic [7:0] r, input int flip,
                              input bit no_de, input bit fall_de,
                              input logic [23:0] fall_px);
        logic [7:0]  gb;
        logic [23:0] px;
        gb = r - 8'd1;
        px = {r, gb, gb};
        drive(1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 4; i++)
            drive(1'b0, !no_de, (i == flip) ? (px ^ 24'h1) : px);
        drive(1'b0, 1'b0, 24'd0);
        drive(1'b1, 1'b0, 24'd0);
        drive(1'b1, 1'b0, 24'd0);
        drive(1'b0, fall_de, fall_de ? fall_px : 24'd0);
        drive(1'b0, 1'b0, 24'd0);
        drive(1'b0, 1'b0, 24'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] r);
        send_frame(r, -1, 1'b0, 1'b0, 24'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, p0, bad, e;

        // 1: reset mid-frame, then SEEK discards the first fall
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 24'd0);
        drive(1'b0, 1'b0, 24'd0);
        drive(1'b0, 1'b1, 24'h050404);
        drive(1'b0, 1'b1, 24'h050404);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outs",
              {locked, frame_done, frame_ok, pix_err, cur_red,
               frame_count, err_count}, 32'd0);
        reset_n = 1'b1;
        send(8'd9);
        check("seek no done", ndone, 0);
        check("seek fcnt", frame_count, 0);

        // 2: acquire on 10..13
        send(8'd10);
        check("first done", ndone, 1);
        check("seed ok", last_ok, 1);
        check("seed red", last_red, 8'd10);
        check("not yet locked", locked, 0);
        send(8'd11);
        send(8'd12);
        check("pre-lock", locked, 0);
        send(8'd13);
        check("lock ok", last_ok, 1);
        check("locked", locked, 1);
        check("fcnt4", frame_count, 4);
        check("ecnt0", err_count, 0);

        // 3: long locked run across the 254 repeat and wrap
        d0 = ndone;
        bad = 0;
        for (int r = 14; r <= 252; r++) begin
            send(8'(r));
            if (!last_ok) bad++;
        end
        check("run bad", bad, 0);
        check("run dones", ndone - d0, 239);
        check("fcnt sat", frame_count, 15);
        send(8'd253);
        check("253 ok", last_ok, 1);
        send(8'd254);
        check("254a ok", last_ok, 1);
        send(8'd254);
        check("254b ok", last_ok, 1);
        check("254b red", last_red, 8'd254);
        send(8'd0);
        check("wrap0 ok", last_ok, 1);
        send(8'd1);
        check("wrap1 ok", last_ok, 1);
        check("wrap ecnt", err_count, 0);
        for (int r = 2; r <= 253; r++)
            send(8'(r));
        send(8'd254);
        send(8'd254);
        send(8'd254);
        check("extra254 ok", last_ok, 0);
        check("extra254 ecnt", err_count, 1);
        check("extra254 lock", locked, 1);
        send(8'd1);
        check("resync ok", last_ok, 1);

        // 4: single-pixel errors
        p0 = npix;
        send_frame(8'd2, 2, 1'b0, 1'b0, 24'd0);
        check("pixerr pulses", npix - p0, 1);
        check("pixerr ok", last_ok, 0);
        check("pixerr ecnt", err_count, 2);
        check("pixerr lock", locked, 1);
        send_frame(8'd3, 1, 1'b0, 1'b0, 24'd0);
        check("pixerr2 pulses", npix - p0, 2);
        check("lost lock", locked, 0);
        check("lost ecnt", err_count, 3);

        // 5: empty frame, then DE on the fall cycle
        send_frame(8'd0, -1, 1'b1, 1'b0, 24'd0);
        check("no de ok", last_ok, 0);
        check("no de ecnt", err_count, 3);
        send_frame(8'd20, -1, 1'b0, 1'b1, 24'h151414);
        check("pre-fall ok", last_ok, 1);
        check("pre-fall red", last_red, 8'd20);
        send_frame(8'd0, -1, 1'b1, 1'b0, 24'd0);
        check("fall px ok", last_ok, 1);
        check("fall px red", last_red, 8'd21);

        // 6: relock, then alternate bad/good to saturate err_count
        send(8'd22);
        send(8'd23);
        check("relock", locked, 1);
        e = 3;
        for (int i = 0; i < 14; i++) begin
            send_frame(8'(24 + 2 * i), 0, 1'b0, 1'b0, 24'd0);
            e = (e == 15) ? 15 : e + 1;
            check("sat bad ok", last_ok, 0);
            check("sat ecnt", err_count, e);
            send(8'(25 + 2 * i));
        end
        check("sat final", err_count, 15);
        check("sat lock", locked, 1);
        check("sat fcnt", frame_count, 15);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
